exam_grade_sequencer: RTL

// - Sequencing controller for the entrance-test grading datapath.
// - Accepts one applicant's section scores serially over a valid/ready stream and accumulates them.
// - Classifies the total as failed, passed or scholarship, and presents the result on a held valid/ready output.
// - Keeps running tallies of applicants, passes and scholarships for the admissions status block.

---
 rtl/grade_pkg.sv | 15 +
 rtl/grade_classifier.sv | 20 ++
 rtl/exam_grade_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/grade_pkg.sv
// Shared types and constants for the entrance-test grading sequencer.
package grade_pkg;

    typedef enum logic {ACCUM, RESULT} state_t;

    localparam int SCORE_W      = 8;
    localparam int DEF_PASS_TH  = 100;
    localparam int DEF_SCHOL_TH = 200;

    // Adding NUM_SECT scores of SCORE_W bits needs clog2(NUM_SECT) extra bits.
    function automatic int sum_width(input int num_sect);
        return SCORE_W + $clog2(num_sect);
    endfunction

endpackage

// File: rtl/grade_classifier.sv
// Combinational classification of an applicant total into failed/passed/scholarship.
module grade_classifier #(
    parameter int SUM_W    = 10,
    parameter int PASS_TH  = 100,
    parameter int SCHOL_TH = 200
) (
    input  logic [SUM_W-1:0] total,
    output logic             failed,
    output logic             passed,
    output logic             schol
);

    // Scholarship threshold sits above the pass threshold, so schol implies passed.
    always_comb begin
        passed = (int'(total) >= PASS_TH);
        schol  = (int'(total) >= SCHOL_TH);
        failed = !passed;
    end

endmodule

// File: rtl/exam_grade_sequencer.sv
// Accepts an applicant's section scores serially, classifies the total and tallies outcomes.
module exam_grade_sequencer
    import grade_pkg::*;
#(
    parameter  int NUM_SECT = 4,
    parameter  int PASS_TH  = DEF_PASS_TH,
    parameter  int SCHOL_TH = DEF_SCHOL_TH,
    parameter  int CNT_W    = 16,
    localparam int SUM_W    = sum_width(NUM_SECT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic [SCORE_W-1:0] score_data,
    input  logic               abort,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [SUM_W-1:0]   result_total,
    output logic               result_failed,
    output logic               result_passed,
    output logic               result_schol,
    input  logic               clear_counts,
    output logic [CNT_W-1:0]   cnt_applicants,
    output logic [CNT_W-1:0]   cnt_passed,
    output logic [CNT_W-1:0]   cnt_schol
);

    localparam int IDX_W = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;

    state_t             state;
    state_t             state_next;
    logic [SUM_W-1:0]   sum;
    logic [IDX_W-1:0]   sect_idx;
    logic [SUM_W-1:0]   total_next;
    logic               last_sect;
    logic               score_hs;
    logic               result_hs;
    logic               cls_failed;
    logic               cls_passed;
    logic               cls_schol;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign total_next = sum + SUM_W'(score_data);
    assign last_sect  = (sect_idx == IDX_W'(NUM_SECT - 1));
    assign score_hs   = score_valid && score_ready;
    assign result_hs  = result_valid && result_ready;

    grade_classifier #(
        .SUM_W    (SUM_W),
        .PASS_TH  (PASS_TH),
        .SCHOL_TH (SCHOL_TH)
    ) u_classifier (
        .total  (total_next),
        .failed (cls_failed),
        .passed (cls_passed),
        .schol  (cls_schol)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (score_hs && last_sect) state_next = RESULT;
            RESULT:  if (result_ready)          state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // abort gates ready so a coincident score is never taken.
    always_comb begin
        score_ready  = (state == ACCUM) && !abort;
        result_valid = (state == RESULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum           <= '0;
            sect_idx      <= '0;
            result_total  <= '0;
            result_failed <= 1'b0;
            result_passed <= 1'b0;
            result_schol  <= 1'b0;
        end else if (state == ACCUM && abort) begin
            sum      <= '0;
            sect_idx <= '0;
        end else if (score_hs) begin
            if (last_sect) begin
                result_total  <= total_next;
                result_failed <= cls_failed;
                result_passed <= cls_passed;
                result_schol  <= cls_schol;
                sum           <= '0;
                sect_idx      <= '0;
            end else begin
                sum      <= total_next;
                sect_idx <= sect_idx + 1'b1;
            end
        end
    end

    // Clear takes priority over a simultaneous result handshake.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_counts) begin
            cnt_applicants <= '0;
            cnt_passed     <= '0;
            cnt_schol      <= '0;
        end else if (result_hs) begin
            cnt_applicants <= sat_inc(cnt_applicants);
            if (result_passed) cnt_passed <= sat_inc(cnt_passed);
            if (result_schol)  cnt_schol  <= sat_inc(cnt_schol);
        end
    end

endmodule
